// File: rtl/riscv_instr_pkg.sv
// RV32IM decode types and the single-instruction decoder.
// Shared by the decode stage and anything that consumes its bundle.
package riscv_instr_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic { SRC1_REG, SRC1_PC } src1_e;
  typedef enum logic { SRC2_REG, SRC2_IMM } src2_e;

  typedef struct packed {
    alu_op_e op;
    src1_e   src1;
    src2_e   src2;
  } alu_control_t;

  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } mdu_op_e;

  typedef struct packed {
    logic    enable;
    mdu_op_e op;
  } mdu_control_t;

  typedef enum logic [2:0] {
    CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU
  } cmp_op_e;

  typedef struct packed {
    logic    enable;
    cmp_op_e op;
  } cmp_control_t;

  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic [1:0] size;
    logic       is_unsigned;
  } mem_control_t;

  typedef enum logic [1:0] {
    WB_ALU, WB_MEM, WB_PC4, WB_MDU
  } wb_src_e;

  typedef struct packed {
    logic       is_write_back;
    logic [4:0] rd;
    wb_src_e    src;
  } wb_control_t;

  typedef struct packed {
    logic         valid;
    logic         is_m;
    alu_control_t alu;
    mdu_control_t mdu;
    cmp_control_t cmp;
    mem_control_t mem;
    wb_control_t  wb;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [31:0]  imm;
    logic         jal;
    logic         jalr;
    logic         use_flag;
  } decoded_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic alu_op_e alu_op(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e r;
    unique case (f3)
      3'd0:    r = alt ? ALU_SUB : ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    r = alt ? ALU_SRA : ALU_SRL;
      3'd6:    r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  function automatic decoded_t decode_instruction(
    input logic [31:0] ins
  );
    decoded_t   d;
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    d = '0;
    d.rs1   = ins[19:15];
    d.rs2   = ins[24:20];
    d.wb.rd = ins[11:7];
    unique case (1'b1)
      opc == OPC_LUI: begin
        d.valid = 1'b1;
        d.rs1 = '0;
        d.alu.src2 = SRC2_IMM;
        d.imm = {ins[31:12], 12'b0};
        d.wb.is_write_back = 1'b1;
      end
      opc == OPC_AUIPC: begin
        d.valid = 1'b1;
        d.alu.src1 = SRC1_PC;
        d.alu.src2 = SRC2_IMM;
        d.imm = {ins[31:12], 12'b0};
        d.wb.is_write_back = 1'b1;
      end
      opc == OPC_JAL: begin
        d.valid = 1'b1;
        d.jal = 1'b1;
        d.alu.src1 = SRC1_PC;
        d.alu.src2 = SRC2_IMM;
        d.imm = {{12{ins[31]}}, ins[19:12],
                 ins[20], ins[30:21], 1'b0};
        d.wb.is_write_back = 1'b1;
        d.wb.src = WB_PC4;
      end
      opc == OPC_JALR: begin
        d.valid = (f3 == 3'd0);
        d.jalr = 1'b1;
        d.alu.src2 = SRC2_IMM;
        d.imm = {{20{ins[31]}}, ins[31:20]};
        d.wb.is_write_back = 1'b1;
        d.wb.src = WB_PC4;
      end
      opc == OPC_BRANCH: begin
        d.valid = (f3 != 3'd2) && (f3 != 3'd3);
        d.cmp.enable = 1'b1;
        d.use_flag = 1'b1;
        case (f3)
          3'd0:    d.cmp.op = CMP_EQ;
          3'd1:    d.cmp.op = CMP_NE;
          3'd4:    d.cmp.op = CMP_LT;
          3'd5:    d.cmp.op = CMP_GE;
          3'd6:    d.cmp.op = CMP_LTU;
          default: d.cmp.op = CMP_GEU;
        endcase
        d.alu.src1 = SRC1_PC;
        d.alu.src2 = SRC2_IMM;
        d.imm = {{20{ins[31]}}, ins[7],
                 ins[30:25], ins[11:8], 1'b0};
      end
      opc == OPC_LOAD: begin
        d.valid = (f3 != 3'd3) && (f3 < 3'd6);
        d.mem.is_load = 1'b1;
        d.mem.size = f3[1:0];
        d.mem.is_unsigned = f3[2];
        d.alu.src2 = SRC2_IMM;
        d.imm = {{20{ins[31]}}, ins[31:20]};
        d.wb.is_write_back = 1'b1;
        d.wb.src = WB_MEM;
      end
      opc == OPC_STORE: begin
        d.valid = (f3 < 3'd3);
        d.mem.is_store = 1'b1;
        d.mem.size = f3[1:0];
        d.alu.src2 = SRC2_IMM;
        d.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      opc == OPC_OPIMM: begin
        d.valid = (f3 == 3'd1) ? (f7 == 7'h00) :
                  (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) :
                  1'b1;
        d.alu.op = alu_op(f3, (f3 == 3'd5) && f7[5]);
        d.alu.src2 = SRC2_IMM;
        d.imm = {{20{ins[31]}}, ins[31:20]};
        d.wb.is_write_back = 1'b1;
      end
      opc == OPC_OP: begin
        d.wb.is_write_back = 1'b1;
        if (f7 == 7'h01) begin
          d.valid = 1'b1;
          d.is_m = 1'b1;
          d.mdu.enable = 1'b1;
          d.mdu.op = mdu_op_e'(f3);
          d.wb.src = WB_MDU;
        end else begin
          d.valid = (f7 == 7'h00) || (f7 == 7'h20 &&
                    (f3 == 3'd0 || f3 == 3'd5));
          d.alu.op = alu_op(f3, f7[5]);
        end
      end
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_queue.sv
// Decode-on-entry FIFO between fetch and issue.
// Illegal pushes latch a trap that blocks fetch until flush.
module decode_queue
  import riscv_instr_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [31:0]                i_instruction,
  input  logic [XLEN-1:0]            i_pc,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [XLEN-1:0]            o_pc,
  output alu_control_t               o_alu_control,
  output mdu_control_t               o_mdu_control,
  output cmp_control_t               o_cmp_control,
  output mem_control_t               o_mem_control,
  output wb_control_t                o_wb_control,
  output logic [4:0]                 o_rs1,
  output logic [4:0]                 o_rs2,
  output logic [31:0]                o_imm,
  output logic                       o_jal,
  output logic                       o_jalr,
  output logic                       o_use_flag,
  output logic                       o_illegal,
  output logic                       o_trap_pending,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    alu_control_t    alu;
    mdu_control_t    mdu;
    cmp_control_t    cmp;
    mem_control_t    mem;
    wb_control_t     wb;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic            jal;
    logic            jalr;
    logic            use_flag;
    logic            illegal;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          ent;
  entry_t          head;
  decoded_t        dec;
  logic            illegal;
  logic            push;
  logic            pop;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            trap_q, trap_d;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign dec     = decode_instruction(i_instruction);
  assign illegal = !dec.valid || (!ENABLE_M && dec.is_m);

  assign o_ready = (count_q < CW'(DEPTH)) && !trap_q;
  assign o_valid = (count_q != '0);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  // Build the stored entry; illegal ones carry no side effects.
  always_comb begin
    ent          = '0;
    ent.pc       = i_pc;
    ent.alu      = dec.alu;
    ent.mdu      = dec.mdu;
    ent.cmp      = dec.cmp;
    ent.mem      = dec.mem;
    ent.wb       = dec.wb;
    ent.rs1      = dec.rs1;
    ent.rs2      = dec.rs2;
    ent.imm      = dec.imm;
    ent.jal      = dec.jal;
    ent.jalr     = dec.jalr;
    ent.use_flag = dec.use_flag;
    ent.illegal  = illegal;
    if (illegal) begin
      ent.wb.is_write_back = 1'b0;
      ent.mem.is_load      = 1'b0;
      ent.mem.is_store     = 1'b0;
      ent.mdu.enable       = 1'b0;
      ent.cmp.enable       = 1'b0;
      ent.jal              = 1'b0;
      ent.jalr             = 1'b0;
      ent.use_flag         = 1'b0;
    end
  end

  // Pointer, occupancy and trap next-state; flush wins.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    trap_d  = trap_q;
    if (i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      trap_d  = 1'b0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (push && illegal) trap_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      trap_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      trap_q  <= trap_d;
    end
  end

  // Entry storage; cleared on reset so the head reads zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !i_flush) begin
      mem_q[wptr_q] <= ent;
    end
  end

  assign head           = mem_q[rptr_q];
  assign o_pc           = head.pc;
  assign o_alu_control  = head.alu;
  assign o_mdu_control  = head.mdu;
  assign o_cmp_control  = head.cmp;
  assign o_mem_control  = head.mem;
  assign o_wb_control   = head.wb;
  assign o_rs1          = head.rs1;
  assign o_rs2          = head.rs2;
  assign o_imm          = head.imm;
  assign o_jal          = head.jal;
  assign o_jalr         = head.jalr;
  assign o_use_flag     = head.use_flag;
  assign o_illegal      = o_valid && head.illegal;
  assign o_trap_pending = trap_q;
  assign o_count        = count_q;

endmodule
